// File: rtl/pulse_gen_seq.sv
// Programmable pulse-train sequencer: start strobe -> R repetitions of (D low, W high).
// All outputs are registered; shadow registers hold config for the whole sequence.
module pulse_gen_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_repeat,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] rep_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        HIGH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] d_q, d_d;
    logic [CNT_W-1:0] w_q, w_d;
    logic [CNT_W-1:0] r_q, r_d;
    logic [CNT_W-1:0] rep_d;
    logic [CNT_W-1:0] rep_inc;
    logic             pulse_d, busy_d, done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            d_q       <= '0;
            w_q       <= '0;
            r_q       <= '0;
            rep_cnt   <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            w_q       <= w_d;
            r_q       <= r_d;
            rep_cnt   <= rep_d;
            pulse_out <= pulse_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        w_d     = w_q;
        r_d     = r_q;
        rep_d   = rep_cnt;
        done_d  = 1'b0;
        rep_inc = rep_cnt + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (start && !abort && (cfg_width != '0)) begin
                    d_d   = cfg_delay;
                    w_d   = cfg_width;
                    r_d   = cfg_repeat;
                    rep_d = '0;
                    if (cfg_delay == '0) begin
                        state_d = HIGH;
                        cnt_d   = cfg_width - CNT_W'(1);
                    end else begin
                        state_d = DELAY;
                        cnt_d   = cfg_delay - CNT_W'(1);
                    end
                end
            end
            DELAY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = w_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HIGH: begin
                // Abort takes priority over end-of-repetition, so rep_cnt is not bumped.
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    rep_d = rep_inc;
                    if ((r_q != '0) && (rep_inc == r_q)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (d_q == '0) begin
                        cnt_d = w_q - CNT_W'(1);
                    end else begin
                        state_d = DELAY;
                        cnt_d   = d_q - CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        pulse_d = (state_d == HIGH);
        busy_d  = (state_d != IDLE);
    end

endmodule
